// File: rtl/clock_sel_ctrl.sv
// Select sequencer for a 4-input glitch-free clock switch: validates the target source,
// drives a stable select through a settle window, and falls back if the active source dies.
module clock_sel_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MIN_EDGES      = 4,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter logic [1:0]  RESET_SEL      = 2'b00,
    parameter logic [1:0]  FALLBACK_SEL   = 2'b00,
    parameter bit          FALLBACK_EN    = 1'b1
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_sel_i,
    output logic       req_ready_o,
    input  logic [3:0] clk_tgl_i,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic [3:0] alive_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EW = $clog2(MIN_EDGES + 1);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES);
    localparam logic [EW-1:0] EDGE_MAX   = EW'(MIN_EDGES);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_DEAD     = 2'b01;
    localparam logic [1:0] CODE_FALLBACK = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SWITCH
    } state_t;

    state_t      state;
    logic [3:0]  tgl_s1;
    logic [3:0]  tgl_s2;
    logic [3:0]  tgl_s3;
    logic [3:0]  tgl_edge;
    logic [TW-1:0] wd_cnt [4];
    logic [3:0]  alive_q;
    logic [3:0]  alive_d1;
    logic [1:0]  target;
    logic [EW-1:0] edge_cnt;
    logic [TW-1:0] win_cnt;
    logic [SW-1:0] settle_cnt;
    logic        fb_mode;
    logic        fb_trig;
    logic [EW-1:0] edge_next;
    logic [TW-1:0] win_next;
    logic [SW-1:0] settle_next;

    // Two synchroniser stages plus one history stage; an edge is any change of the divided clock.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            tgl_s1 <= '0;
            tgl_s2 <= '0;
            tgl_s3 <= '0;
        end else begin
            tgl_s1 <= clk_tgl_i;
            tgl_s2 <= tgl_s1;
            tgl_s3 <= tgl_s2;
        end
    end

    assign tgl_edge = tgl_s2 ^ tgl_s3;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                wd_cnt[i] <= '0;
            end
            alive_q  <= '0;
            alive_d1 <= '0;
        end else begin
            alive_d1 <= alive_q;
            for (int unsigned i = 0; i < 4; i++) begin
                if (tgl_edge[i]) begin
                    wd_cnt[i]  <= '0;
                    alive_q[i] <= 1'b1;
                end else if (wd_cnt[i] != TO_MAX) begin
                    wd_cnt[i] <= wd_cnt[i] + TW'(1);
                    if (wd_cnt[i] == TO_MAX - TW'(1)) begin
                        alive_q[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign alive_o = alive_q;

    // Only a 1->0 transition of the active source observed while idle triggers fallback.
    assign fb_trig = FALLBACK_EN && (state == ST_IDLE) && alive_d1[sel_o] && !alive_q[sel_o]
                     && (sel_o != FALLBACK_SEL);

    assign req_ready_o = (state == ST_IDLE) && !fb_trig;
    assign busy_o      = (state != ST_IDLE);

    assign edge_next   = edge_cnt + EW'(tgl_edge[target]);
    assign win_next    = win_cnt + TW'(1);
    assign settle_next = settle_cnt + SW'(1);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= ST_IDLE;
            sel_o      <= RESET_SEL;
            target     <= RESET_SEL;
            edge_cnt   <= '0;
            win_cnt    <= '0;
            settle_cnt <= '0;
            fb_mode    <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= CODE_NONE;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fb_trig) begin
                        state      <= ST_SWITCH;
                        target     <= FALLBACK_SEL;
                        sel_o      <= FALLBACK_SEL;
                        settle_cnt <= '0;
                        fb_mode    <= 1'b1;
                        err_o      <= 1'b1;
                        err_code_o <= CODE_FALLBACK;
                    end else if (req_valid_i) begin
                        if (req_sel_i == sel_o) begin
                            done_o <= 1'b1;
                        end else begin
                            state    <= ST_CHECK;
                            target   <= req_sel_i;
                            edge_cnt <= '0;
                            win_cnt  <= '0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (edge_next >= EDGE_MAX) begin
                        state      <= ST_SWITCH;
                        sel_o      <= target;
                        settle_cnt <= '0;
                        fb_mode    <= 1'b0;
                    end else if (win_next >= TO_MAX) begin
                        state      <= ST_IDLE;
                        err_o      <= 1'b1;
                        err_code_o <= CODE_DEAD;
                    end else begin
                        edge_cnt <= edge_next;
                        win_cnt  <= win_next;
                    end
                end
                ST_SWITCH: begin
                    if (settle_next >= SETTLE_MAX) begin
                        state  <= ST_IDLE;
                        done_o <= !fb_mode;
                    end else begin
                        settle_cnt <= settle_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_sel_ctrl.sv
// Bench for clock_sel_ctrl: table-driven requests with a pulse scoreboard,
// plus fallback and mid-switch reset sequences.
module tb_clock_sel_ctrl;

    localparam int TO     = 64;
    localparam int SETTLE = 16;

    logic       clk_i = 1'b0;
    logic       arstn_i = 1'b0;
    logic       req_valid_i = 1'b0;
    logic [1:0] req_sel_i = 2'b00;
    logic [3:0] clk_tgl_i = 4'b0000;
    logic       req_ready_o;
    logic [1:0] sel_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [1:0] err_code_o;
    logic [3:0] alive_o;

    clock_sel_ctrl #(
        .TIMEOUT_CYCLES(64),
        .MIN_EDGES(4),
        .SETTLE_CYCLES(16),
        .RESET_SEL(2'b00),
        .FALLBACK_SEL(2'b00),
        .FALLBACK_EN(1'b1)
    ) dut (
        .clk_i(clk_i),
        .arstn_i(arstn_i),
        .req_valid_i(req_valid_i),
        .req_sel_i(req_sel_i),
        .req_ready_o(req_ready_o),
        .clk_tgl_i(clk_tgl_i),
        .sel_o(sel_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .err_code_o(err_code_o),
        .alive_o(alive_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         is_err;
        logic [1:0] sel;
        logic [1:0] code;
        bit         chk_settle;
        bit         chk_tmo;
    } exp_t;

    typedef struct {
        logic [1:0] req_sel;
        logic [3:0] stuck;
        bit         is_err;
        logic [1:0] exp_sel;
        logic [1:0] exp_code;
        bit         exp_busy;
    } vec_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int sel_chg_cyc = 0;
    logic [3:0] run = 4'hF;
    int per[4];
    int tcnt[4];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Divided-clock sources: each running source toggles every per[n] reference cycles.
    initial begin
        per[0] = 2; per[1] = 3; per[2] = 4; per[3] = 5;
        for (int n = 0; n < 4; n++) tcnt[n] = 0;
        forever begin
            @(negedge clk_i);
            for (int n = 0; n < 4; n++) begin
                if (run[n]) begin
                    tcnt[n]++;
                    if (tcnt[n] >= per[n]) begin
                        tcnt[n] = 0;
                        clk_tgl_i[n] = ~clk_tgl_i[n];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    // Pulse monitor: every done/err pulse must match the oldest scoreboard entry.
    initial begin
        logic [1:0] prev;
        exp_t e;
        prev = 2'b00;
        forever begin
            @(negedge clk_i);
            if (!arstn_i) begin
                prev = sel_o;
            end else begin
                if (sel_o != prev) sel_chg_cyc = cyc;
                prev = sel_o;
                if (done_o || err_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", {done_o, err_o}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("pulse_kind", {done_o, err_o}, e.is_err ? 1 : 2);
                        chk("pulse_sel", sel_o, e.sel);
                        chk("pulse_code", err_code_o, e.code);
                        if (e.chk_settle) chk("settle_len", cyc - sel_chg_cyc, SETTLE);
                        if (e.chk_tmo) chk("check_timeout_len", cyc - acc_cyc, TO);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready_o && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        chk("ready_before_req", req_ready_o, 1);
    endtask

    task automatic wait_sb_empty();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk_i);
            k++;
        end
        if (sb.size() != 0) begin
            chk("pulse_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        if (v.stuck != 4'b0000) begin
            run = run & ~v.stuck;
            repeat (10) @(negedge clk_i);
        end
        wait_ready();
        req_valid_i = 1'b1;
        req_sel_i   = v.req_sel;
        e = '{v.is_err, v.exp_sel, v.exp_code, (!v.is_err && v.exp_busy), v.is_err};
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        acc_cyc     = cyc;
        req_valid_i = 1'b0;
        req_sel_i   = ~v.req_sel;
        chk("busy_after_accept", busy_o, v.exp_busy);
        wait_sb_empty();
        @(negedge clk_i);
        chk("busy_after_pulse", busy_o, 0);
        if (v.stuck != 4'b0000) begin
            run = 4'hF;
            repeat (10) @(negedge clk_i);
        end
    endtask

    initial begin
        vec_t vt[7];
        vec_t vsame;
        exp_t e;
        int k;

        vt[0] = '{2'b01, 4'b0000, 1'b0, 2'b01, 2'b00, 1'b1};
        vt[1] = '{2'b01, 4'b0000, 1'b0, 2'b01, 2'b00, 1'b0};
        vt[2] = '{2'b10, 4'b0100, 1'b1, 2'b01, 2'b01, 1'b1};
        vt[3] = '{2'b11, 4'b0000, 1'b0, 2'b11, 2'b01, 1'b1};
        vt[4] = '{2'b00, 4'b0000, 1'b0, 2'b00, 2'b01, 1'b1};
        vt[5] = '{2'b10, 4'b0000, 1'b0, 2'b10, 2'b01, 1'b1};
        vt[6] = '{2'b01, 4'b0000, 1'b0, 2'b01, 2'b01, 1'b1};
        vsame = '{2'b00, 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0};

        // Reset state with all sources toggling
        repeat (3) @(negedge clk_i);
        chk("rst_sel", sel_o, 0);
        chk("rst_alive", alive_o, 0);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_code", err_code_o, 0);
        chk("rst_pulses", {done_o, err_o}, 0);
        arstn_i = 1'b1;
        repeat (TO + 3) @(negedge clk_i);
        chk("alive_all", alive_o, 15);
        chk("idle_sel", sel_o, 0);
        chk("idle_ready", req_ready_o, 1);

        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Active source B dies in IDLE: fallback to A, same-cycle request refused
        run[1] = 1'b0;
        k = 0;
        while (alive_o[1] && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        chk("alive_b_fall_window", (k >= 60 && k <= 72) ? 1 : 0, 1);
        chk("ready_on_fallback", req_ready_o, 0);
        req_valid_i = 1'b1;
        req_sel_i   = 2'b11;
        e = '{1'b1, 2'b00, 2'b10, 1'b0, 1'b0};
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        chk("fb_busy", busy_o, 1);
        chk("fb_sel", sel_o, 0);
        wait_sb_empty();
        repeat (SETTLE + 4) @(negedge clk_i);
        chk("fb_done_idle", busy_o, 0);
        chk("fb_req_ignored_sel", sel_o, 0);

        // Reset asserted 5 cycles into SWITCH
        run[1] = 1'b1;
        repeat (10) @(negedge clk_i);
        wait_ready();
        req_valid_i = 1'b1;
        req_sel_i   = 2'b01;
        e = '{1'b0, 2'b01, 2'b10, 1'b1, 1'b0};
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        k = 0;
        while (sel_o != 2'b01 && k < 100) begin
            @(negedge clk_i);
            k++;
        end
        chk("switch_entry_seen", sel_o, 1);
        repeat (5) @(negedge clk_i);
        chk("busy_before_reset", busy_o, 1);
        arstn_i = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_sel", sel_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ready", req_ready_o, 1);
        chk("mid_rst_alive", alive_o, 0);
        chk("mid_rst_code", err_code_o, 0);
        chk("mid_rst_pulses", {done_o, err_o}, 0);
        repeat (3) @(negedge clk_i);
        arstn_i = 1'b1;
        repeat (TO + 3) @(negedge clk_i);
        chk("post_rst_alive", alive_o, 15);
        chk("post_rst_sel", sel_o, 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_code", err_code_o, 0);
        run_vec(vsame);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
